// File: rtl/axis_sync_fifo_video.sv
// AXI-Stream first-word-fall-through FIFO on block RAM, with level and threshold flags.
// Define AXIS_FIFO_FRAME_CNT_EN to enable counting of stored tlast beats (frame_cnt/frame_avail).
module axis_sync_fifo_video #(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH_WIDTH      = 10,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  input  logic                   flush,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   frame_cnt,
  output logic                   frame_avail
);

  localparam int                 DEPTH    = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] CAPACITY = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [31:0]        AF_TH    = 32'(ALMOST_FULL_NUM);
  localparam logic [31:0]        AE_TH    = 32'(ALMOST_EMPTY_NUM);

  // Each RAM word carries tlast in its top bit above tdata.
  logic [DATA_WIDTH:0]    mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   ram_count;
  logic [DATA_WIDTH:0]    q_word;
  logic                   q_valid;
  logic                   wr_beat;
  logic                   rd_beat;
  logic                   move;
  logic                   ram_rd;
  logic [31:0]            level_ext;

  assign s_tready = (water_level < CAPACITY) && rst_n && !flush;
  assign wr_beat  = s_tvalid && s_tready;
  assign rd_beat  = m_tvalid && m_tready;

  // The RAM output register (q) and the output register form a two-entry prefetch;
  // q advances whenever the output register is empty or being consumed.
  assign move   = q_valid && (!m_tvalid || m_tready);
  assign ram_rd = (ram_count != '0) && (!q_valid || move);

  always_ff @(posedge clk) begin
    if (wr_beat) begin
      mem[wr_ptr] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (ram_rd) begin
      q_word <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_count   <= '0;
      q_valid     <= 1'b0;
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_tlast     <= 1'b0;
      water_level <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_count   <= '0;
      q_valid     <= 1'b0;
      m_tvalid    <= 1'b0;
      water_level <= '0;
    end else begin
      if (wr_beat) wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd)  rd_ptr <= rd_ptr + 1'b1;
      ram_count <= ram_count + (DEPTH_WIDTH+1)'(wr_beat) - (DEPTH_WIDTH+1)'(ram_rd);

      if (ram_rd)    q_valid <= 1'b1;
      else if (move) q_valid <= 1'b0;

      if (move) begin
        {m_tlast, m_tdata} <= q_word;
        m_tvalid           <= 1'b1;
      end else if (rd_beat) begin
        m_tvalid <= 1'b0;
      end

      case ({wr_beat, rd_beat})
        2'b10:   water_level <= water_level + 1'b1;
        2'b01:   water_level <= water_level - 1'b1;
        default: water_level <= water_level;
      endcase
    end
  end

  // Thresholds are compared at 32 bits so large parameter values never truncate.
  assign level_ext    = 32'(water_level);
  assign almost_full  = (level_ext >= AF_TH);
  assign almost_empty = (level_ext <= AE_TH);

`ifdef AXIS_FIFO_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      frame_cnt <= '0;
    end else begin
      case ({wr_beat && s_tlast, rd_beat && m_tlast})
        2'b10:   frame_cnt <= frame_cnt + 1'b1;
        2'b01:   frame_cnt <= frame_cnt - 1'b1;
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  assign frame_avail = (frame_cnt != '0);
`else
  assign frame_cnt   = '0;
  assign frame_avail = 1'b1;
`endif

endmodule

// File: tb/tb_axis_sync_fifo_video.sv
// Randomized and directed bench for axis_sync_fifo_video against a queue-based reference.
// Honours AXIS_FIFO_FRAME_CNT_EN the same way as the design.
module tb_axis_sync_fifo_video;

  localparam int DW  = 32;
  localparam int DPW = 4;
  localparam int CAP = 16;
  localparam int AF  = 14;
  localparam int AE  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic          flush;
  logic [DPW:0]  water_level;
  logic          almost_full;
  logic          almost_empty;
  logic [DPW:0]  frame_cnt;
  logic          frame_avail;

  always #5 clk = ~clk;

  axis_sync_fifo_video #(
    .DATA_WIDTH(DW), .DEPTH_WIDTH(DPW),
    .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .flush(flush), .water_level(water_level),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .frame_cnt(frame_cnt), .frame_avail(frame_avail)
  );

  // Reference: stored words in order, each stamped with the edge index it was written at.
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            t;
  } entry_t;

  entry_t mq[$];
  int     checks = 0;
  int     errors = 0;
  int     ecount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ecount);
    end
  endtask

  // A word is visible at the output two edges after it was written, once it is at the head.
  function automatic logic expValid();
    return (mq.size() > 0) && (ecount >= mq[0].t + 2);
  endfunction

  function automatic int frameCount();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  task automatic checkAll();
    int lvl = mq.size();
    checkOutput("s_tready", s_tready, (lvl < CAP) && rst_n && !flush);
    checkOutput("m_tvalid", m_tvalid, expValid());
    if (expValid()) begin
      checkOutput("m_tdata", m_tdata, mq[0].data);
      checkOutput("m_tlast", m_tlast, mq[0].last);
    end
    checkOutput("water_level", water_level, lvl);
    checkOutput("almost_full", almost_full, lvl >= AF);
    checkOutput("almost_empty", almost_empty, lvl <= AE);
`ifdef AXIS_FIFO_FRAME_CNT_EN
    checkOutput("frame_cnt", frame_cnt, frameCount());
    checkOutput("frame_avail", frame_avail, frameCount() != 0);
`else
    checkOutput("frame_cnt", frame_cnt, 0);
    checkOutput("frame_avail", frame_avail, 1'b1);
`endif
  endtask

  task automatic applyStimulus(input logic sv, input logic [DW-1:0] d, input logic l,
                               input logic mr, input logic fl, input logic rs);
    logic wr;
    logic rd;
    s_tvalid = sv;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = mr;
    flush    = fl;
    rst_n    = rs;
    #1;
    checkAll();
    wr = sv && (mq.size() < CAP) && rs && !fl;
    rd = expValid() && mr;
    @(posedge clk);
    #1;
    ecount++;
    if (!rs || fl) begin
      mq.delete();
    end else begin
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back('{data: d, last: l, t: ecount});
    end
  endtask

  initial begin
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    m_tready = 1'b0; flush = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    ecount++;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_tdata", m_tdata, 0);
    checkOutput("rst_tlast", m_tlast, 0);

    // Single word, held under backpressure, then consumed.
    applyStimulus(1, 32'h11, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("lat_not_yet", m_tvalid, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("lat_valid", m_tvalid, 1);
    checkOutput("lat_data", m_tdata, 32'h11);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);

    // Fill to capacity, push extra, then drain.
    for (int i = 0; i < CAP; i++) applyStimulus(1, i, 0, 0, 0, 1);
    checkOutput("full_level", water_level, CAP);
    checkOutput("full_ready", s_tready, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'hDEAD, 0, 0, 0, 1);
    for (int i = 0; i < CAP + 3; i++) applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("drained_level", water_level, 0);

    // Streaming 40 words with reads held high; pointers wrap.
    for (int i = 0; i < 40; i++) applyStimulus(1, i, i[0], 1, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 1);

    // Flush at level 5 with both beats requested.
    for (int i = 0; i < 5; i++) applyStimulus(1, 100 + i, i == 2, 0, 0, 1);
    applyStimulus(1, 32'hBAD, 1, 1, 1, 1);
    checkOutput("flush_level", water_level, 0);
    checkOutput("flush_valid", m_tvalid, 0);
    checkOutput("flush_frames", frame_cnt, 0);

    // Three lines of four words, then read one line.
    for (int i = 1; i <= 12; i++) applyStimulus(1, 200 + i, (i % 4) == 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);

    // Reset at level 9.
    for (int i = 0; i < 9; i++) applyStimulus(1, 300 + i, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst9_level", water_level, 0);
    checkOutput("rst9_empty", almost_empty, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Random traffic with varying bias, rare flushes and resets.
    for (int blk = 0; blk < 6; blk++) begin
      int wbias = $urandom_range(1, 9);
      int rbias = $urandom_range(1, 9);
      for (int i = 0; i < 300; i++) begin
        applyStimulus($urandom_range(0, 9) < wbias, $urandom, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) < rbias, $urandom_range(0, 99) == 0,
                      $urandom_range(0, 199) != 0);
      end
    end
    for (int i = 0; i < CAP + 4; i++) applyStimulus(0, 0, 0, 1, 0, 1);
    checkAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
